// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversamples rx on the rx_enb strobe, frames DATA_BITS LSB-first
// and presents each byte through a valid/ready holding register with error pulses.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enb,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           sync_q, sync_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 rx_s;
  logic                 load_c;
  logic                 ferr_c;

  assign rx_s = sync_q[1];

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      sync_q        <= '1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      sync_q        <= sync_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Next-state: framing FSM advances only on oversample ticks
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    sync_d  = {sync_q[0], rx};
    load_c  = 1'b0;
    ferr_c  = 1'b0;
    if (rx_enb) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (!rx_s) begin
              state_d = S_DATA;
              idx_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_END) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              state_d = S_STOP;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_END) begin
            cnt_d = '0;
            if (rx_s) begin
              load_c  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_c  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BREAK: begin
          // a line held low must return high before a new start can be seen
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: holding register with valid/ready handshake and error pulses
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = ferr_c;
    overrun_err_d = 1'b0;
    if (load_c) begin
      rx_data_d     = shift_q;
      rx_valid_d    = 1'b1;
      overrun_err_d = rx_valid_q & ~rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level event model (sample tick computed arithmetically from
// the frame start) plus a holding-register scoreboard checked every clock.
module tb_uart_rx;

  localparam int unsigned DB = 8;
  localparam int unsigned OS = 16;
  // ticks from the tick after which the start bit is driven to the stop-bit sample tick
  localparam int unsigned STOP_OFS = 1 + OS / 2 + OS * (DB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_enb;
  logic          rx;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun_err;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_enb     (rx_enb),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   tick;
    bit            is_load;
    logic [DB-1:0] data;
  } ev_t;

  ev_t           evq[$];
  int unsigned   tick_no = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            obs_valid = 0;
  int            obs_ferr = 0;
  int            obs_ovr = 0;
  logic [DB-1:0] obs_last = '0;
  bit            rand_rdy = 1'b0;
  logic          rdy_level = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Oversample strobe: one clk in four
  initial begin
    int ph;
    ph = 0;
    rx_enb = 1'b0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      rx_enb = (ph == 0);
    end
  end

  initial begin
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      rx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  // Scoreboard: apply frame events and handshake, then compare every cycle
  initial begin
    logic [DB-1:0] data_m;
    logic          valid_m;
    bit            exp_fe, exp_ov, hit;
    ev_t           ev;
    data_m  = '0;
    valid_m = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      hit    = 1'b0;
      if (rx_enb) tick_no++;
      if (rst) begin
        valid_m = 1'b0;
        data_m  = '0;
        evq.delete();
      end else begin
        if (rx_enb && evq.size() > 0 && evq[0].tick == tick_no) begin
          ev  = evq.pop_front();
          hit = 1'b1;
        end
        if (hit && ev.is_load) begin
          exp_ov  = valid_m && !rx_ready;
          data_m  = ev.data;
          valid_m = 1'b1;
        end else begin
          if (hit) exp_fe = 1'b1;
          if (valid_m && rx_ready) valid_m = 1'b0;
        end
      end
      check("rx_valid", 32'(rx_valid), 32'(valid_m));
      check("rx_data", 32'(rx_data), 32'(data_m));
      check("frame_err", 32'(frame_err), 32'(exp_fe));
      check("overrun_err", 32'(overrun_err), 32'(exp_ov));
      if (rx_valid) begin
        obs_valid++;
        obs_last = rx_data;
      end
      if (frame_err) obs_ferr++;
      if (overrun_err) obs_ovr++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  // Returns 2 time units after the n-th next tick edge
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!rx_enb);
    end
    #2;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit stop_ok, input int extra_low);
    ev_t e;
    tick_wait(1);
    e.tick    = tick_no + STOP_OFS;
    e.is_load = stop_ok;
    e.data    = d;
    evq.push_back(e);
    rx = 1'b0;
    tick_wait(OS);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      tick_wait(OS);
    end
    rx = stop_ok;
    tick_wait(OS);
    if (!stop_ok && extra_low > 0) tick_wait(extra_low);
    rx = 1'b1;
  endtask

  task automatic send_glitch(input int n);
    tick_wait(1);
    rx = 1'b0;
    tick_wait(n);
    rx = 1'b1;
  endtask

  task automatic send_partial(input logic [DB-1:0] d, input int nbits);
    tick_wait(1);
    rx = 1'b0;
    tick_wait(OS);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      tick_wait(OS);
    end
    rx = d[nbits];
    tick_wait(OS / 2);
  endtask

  initial begin
    int v0, f0, o0;
    logic [DB-1:0] d;
    bit ok;
    rst = 1'b1;
    rx  = 1'b1;
    rdy_level = 1'b1;
    #2;
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_data", 32'(rx_data), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_ovr", 32'(overrun_err), 32'h0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    tick_wait(4);

    // 0xA5 with ready high: one valid cycle
    v0 = obs_valid; f0 = obs_ferr; o0 = obs_ovr;
    send_frame(8'hA5, 1'b1, 0);
    tick_wait(4);
    check("a5_valid_cycles", 32'(obs_valid - v0), 32'd1);
    check("a5_data", 32'(obs_last), 32'hA5);
    check("a5_errs", 32'((obs_ferr - f0) + (obs_ovr - o0)), 32'd0);

    // 0x3C held, then one-cycle ready
    rdy_level = 1'b0;
    tick_wait(2);
    send_frame(8'h3C, 1'b1, 0);
    tick_wait(4);
    check("3c_valid_held", 32'(rx_valid), 32'h1);
    check("3c_data", 32'(rx_data), 32'h3C);
    rdy_level = 1'b1;
    @(posedge clk);
    #2 rdy_level = 1'b0;
    check("3c_valid_drop", 32'(rx_valid), 32'h0);

    // Overrun: 0x11 then 0x22 unconsumed
    tick_wait(2);
    o0 = obs_ovr;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    tick_wait(4);
    check("ovr_pulses", 32'(obs_ovr - o0), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_valid", 32'(rx_valid), 32'h1);

    // Glitch rejection, then 0x55
    rdy_level = 1'b1;
    tick_wait(2);
    v0 = obs_valid; f0 = obs_ferr; o0 = obs_ovr;
    send_glitch(5);
    tick_wait(2 * OS);
    check("glitch_valid", 32'(obs_valid - v0), 32'd0);
    check("glitch_errs", 32'((obs_ferr - f0) + (obs_ovr - o0)), 32'd0);
    send_frame(8'h55, 1'b1, 0);
    tick_wait(4);
    check("55_valid_cycles", 32'(obs_valid - v0), 32'd1);
    check("55_data", 32'(obs_last), 32'h55);

    // Framing error with break, then 0x81 left pending
    v0 = obs_valid; f0 = obs_ferr;
    send_frame(8'hFF, 1'b0, 3 * OS);
    tick_wait(4);
    check("fe_pulses", 32'(obs_ferr - f0), 32'd1);
    check("fe_valid", 32'(obs_valid - v0), 32'd0);
    rdy_level = 1'b0;
    send_frame(8'h81, 1'b1, 0);
    tick_wait(4);
    check("81_data", 32'(rx_data), 32'h81);
    check("81_valid", 32'(rx_valid), 32'h1);
    check("81_ferr", 32'(obs_ferr - f0), 32'd1);

    // Async reset during data bit 3 of 0x96
    send_partial(8'h96, 3);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(rx_valid), 32'h0);
    check("rst_mid_data", 32'(rx_data), 32'h0);
    check("rst_mid_errs", 32'({frame_err, overrun_err}), 32'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    rdy_level = 1'b1;
    tick_wait(4);
    v0 = obs_valid; f0 = obs_ferr; o0 = obs_ovr;
    send_frame(8'h69, 1'b1, 0);
    tick_wait(4);
    check("69_valid_cycles", 32'(obs_valid - v0), 32'd1);
    check("69_data", 32'(obs_last), 32'h69);
    check("69_errs", 32'((obs_ferr - f0) + (obs_ovr - o0)), 32'd0);

    // Random frames, stop errors and consumer back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d  = DB'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(d, ok, ok ? 0 : int'($urandom_range(0, 40)));
      tick_wait(int'($urandom_range(0, 12)));
    end
    tick_wait(4);
    rand_rdy = 1'b0;
    rdy_level = 1'b1;
    tick_wait(8);
    check("pending_events", 32'(evq.size()), 32'd0);
    check("final_valid", 32'(rx_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
